// File: rtl/axi_ddr_port_merger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_ddr_port_merger_pkg
// Description : Shared types and constants for the AXI4 to DDR-port merger.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_ddr_port_merger_pkg;

  // Downstream DDR port carries a fixed 8-bit transaction ID
  localparam int DDR_ID_WIDTH = 8;

  // Shared address channel direction select
  localparam logic ATYPE_WRITE = 1'b1;
  localparam logic ATYPE_READ  = 1'b0;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_A_REQ  = 3'd1,
    ST_W_DATA = 3'd2,
    ST_B_RESP = 3'd3,
    ST_R_DATA = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/axi_ddr_port_merger_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rr_arbiter2
// Description : Two-request (write/read) round-robin arbiter. The request that
//               was not granted last wins a tie; reset favours read first.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rr_arbiter2
  import axi_ddr_port_merger_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic i_en,
  input  logic i_req_wr,
  input  logic i_req_rd,
  output logic o_gnt_wr,
  output logic o_gnt_rd
);

  // Direction of the most recent grant (ATYPE_WRITE / ATYPE_READ)
  logic r_last_grant;

  assign o_gnt_wr = i_en & i_req_wr & (~i_req_rd | (r_last_grant == ATYPE_READ));
  assign o_gnt_rd = i_en & i_req_rd & ~o_gnt_wr;

  // Remember who won so the other side gets priority on the next tie
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last_grant <= ATYPE_WRITE;
    end else if (o_gnt_wr) begin
      r_last_grant <= ATYPE_WRITE;
    end else if (o_gnt_rd) begin
      r_last_grant <= ATYPE_READ;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_ddr_port_merger.sv
`default_nettype none
// ============================================================================
// Module      : axi_ddr_port_merger
// Description : AXI4 slave to DDR-port master bridge. Merges AW/AR onto one
//               shared address channel and keeps one transaction in flight.
//               Flags write bursts whose wlast disagrees with awlen.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ddr_port_merger
  import axi_ddr_port_merger_pkg::*;
#(
  parameter int DATA_WIDTH = 128,  // 32/64/128/256/512/1024
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    io_memoryClk,
  input  logic                    resetn,
  // AXI write address
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awlock,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  // AXI write data
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  // AXI write response
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  // AXI read address
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arlock,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  // AXI read data
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  // DDR shared address channel
  output logic [7:0]              m_aid,
  output logic [31:0]             m_aaddr,
  output logic [7:0]              m_alen,
  output logic [2:0]              m_asize,
  output logic [1:0]              m_aburst,
  output logic [1:0]              m_alock,
  output logic                    m_atype,
  output logic                    m_avalid,
  input  logic                    m_aready,
  // DDR write data
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  // DDR write response
  input  logic [7:0]              m_bid,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  // DDR read data
  input  logic [7:0]              m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  // Sticky protocol error
  output logic                    err_wlast
);

  state_e     r_state;
  logic [7:0] r_beat;
  logic       w_gnt_wr;
  logic       w_gnt_rd;
  logic       w_arb_en;
  logic       w_st_w;
  logic       w_st_b;
  logic       w_st_r;
  logic       w_w_hs;

  // Arbitration only happens in IDLE and never while reset is asserted,
  // so the combinational AXI readies stay low during reset
  assign w_arb_en = (r_state == ST_IDLE) & resetn;

  axi_rr_arbiter2 u_arb (
    .clk      (io_memoryClk),
    .resetn   (resetn),
    .i_en     (w_arb_en),
    .i_req_wr (s_awvalid),
    .i_req_rd (s_arvalid),
    .o_gnt_wr (w_gnt_wr),
    .o_gnt_rd (w_gnt_rd)
  );

  assign s_awready = w_gnt_wr;
  assign s_arready = w_gnt_rd;

  assign w_st_w = (r_state == ST_W_DATA);
  assign w_st_b = (r_state == ST_B_RESP);
  assign w_st_r = (r_state == ST_R_DATA);
  assign w_w_hs = w_st_w & s_wvalid & m_wready;

  // Data/ID paths are always forwarded; only the handshakes are state-gated
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;
  assign m_wlast  = s_wlast;
  assign m_wvalid = w_st_w & s_wvalid;
  assign s_wready = w_st_w & m_wready;

  assign s_bid    = ID_WIDTH'(m_bid);
  assign s_bresp  = 2'b00;
  assign s_bvalid = w_st_b & m_bvalid;
  assign m_bready = w_st_b & s_bready;

  assign s_rid    = ID_WIDTH'(m_rid);
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;
  assign s_rvalid = w_st_r & m_rvalid;
  assign m_rready = w_st_r & s_rready;

  // Transaction sequencer: latch the granted request, present it downstream,
  // then pass data through until the burst or response completes
  always_ff @(posedge io_memoryClk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_beat    <= 8'd0;
      err_wlast <= 1'b0;
      m_avalid  <= 1'b0;
      m_aid     <= 8'd0;
      m_aaddr   <= 32'd0;
      m_alen    <= 8'd0;
      m_asize   <= 3'd0;
      m_aburst  <= 2'd0;
      m_alock   <= 2'd0;
      m_atype   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_wr) begin
            m_aid    <= DDR_ID_WIDTH'(s_awid);
            m_aaddr  <= 32'(s_awaddr);
            m_alen   <= s_awlen;
            m_asize  <= s_awsize;
            m_aburst <= s_awburst;
            m_alock  <= {1'b0, s_awlock};
            m_atype  <= ATYPE_WRITE;
            m_avalid <= 1'b1;
            r_state  <= ST_A_REQ;
          end else if (w_gnt_rd) begin
            m_aid    <= DDR_ID_WIDTH'(s_arid);
            m_aaddr  <= 32'(s_araddr);
            m_alen   <= s_arlen;
            m_asize  <= s_arsize;
            m_aburst <= s_arburst;
            m_alock  <= {1'b0, s_arlock};
            m_atype  <= ATYPE_READ;
            m_avalid <= 1'b1;
            r_state  <= ST_A_REQ;
          end
        end
        ST_A_REQ: begin
          if (m_aready) begin
            m_avalid <= 1'b0;
            r_state  <= (m_atype == ATYPE_WRITE) ? ST_W_DATA : ST_R_DATA;
          end
        end
        ST_W_DATA: begin
          if (w_w_hs) begin
            if (r_beat == m_alen) begin
              r_beat  <= 8'd0;
              r_state <= ST_B_RESP;
              if (!s_wlast) err_wlast <= 1'b1;
            end else begin
              r_beat <= r_beat + 8'd1;
              if (s_wlast) err_wlast <= 1'b1;
            end
          end
        end
        ST_B_RESP: begin
          if (m_bvalid && s_bready) r_state <= ST_IDLE;
        end
        ST_R_DATA: begin
          if (m_rvalid && s_rready && m_rlast) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_ddr_port_merger.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_ddr_port_merger
// Description : Self-checking bench: upstream AXI master and downstream DDR
//               port models, with a transaction-level reference for ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_ddr_port_merger;

  localparam int DW = 128;
  localparam int IW = 8;
  localparam int AW = 32;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic        wr;
  } txn_t;

  typedef struct {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic            last;
  } wbeat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [7:0]    id;
    logic [1:0]    resp;
    logic          last;
  } rbeat_t;

  logic io_memoryClk, resetn;
  logic [IW-1:0] s_awid, s_arid, s_bid, s_rid;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [7:0] s_awlen, s_arlen;
  logic [2:0] s_awsize, s_arsize;
  logic [1:0] s_awburst, s_arburst, s_bresp, s_rresp;
  logic s_awlock, s_arlock, s_awvalid, s_awready, s_arvalid, s_arready;
  logic [DW-1:0] s_wdata, s_rdata, m_wdata, m_rdata;
  logic [DW/8-1:0] s_wstrb, m_wstrb;
  logic s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_rlast, s_rvalid, s_rready;
  logic [7:0] m_aid, m_alen, m_bid, m_rid;
  logic [31:0] m_aaddr;
  logic [2:0] m_asize;
  logic [1:0] m_aburst, m_alock, m_rresp;
  logic m_atype, m_avalid, m_aready;
  logic m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_rlast, m_rvalid, m_rready, err_wlast;

  axi_ddr_port_merger #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .io_memoryClk(io_memoryClk), .resetn(resetn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_aid(m_aid), .m_aaddr(m_aaddr), .m_alen(m_alen), .m_asize(m_asize), .m_aburst(m_aburst),
    .m_alock(m_alock), .m_atype(m_atype), .m_avalid(m_avalid), .m_aready(m_aready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .err_wlast(err_wlast)
  );

  initial io_memoryClk = 1'b0;
  always #5 io_memoryClk = ~io_memoryClk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Upstream stimulus queues
  txn_t   aw_q[$];
  txn_t   ar_q[$];
  wbeat_t w_q[$];
  // Observed events
  txn_t   a_log[$];
  wbeat_t mw_log[$];
  rbeat_t r_log[$];
  rbeat_t r_sent[$];
  logic [7:0] b_log[$];
  logic [1:0] bresp_log[$];
  logic   grant_type[$];
  int     grant_cyc[$];
  int     rise_cyc[$];
  int     rdone_cyc[$];
  logic   prev_avalid = 1'b0;

  // Handshake throttles (percent)
  int wvalid_pct = 100, bready_pct = 100, rready_pct = 100;
  int wready_pct = 100, rvalid_pct = 100, aready_delay = 0;

  // Downstream port model: 0 idle, 1 address wait, 2 write data, 3 response, 4 read data
  int dn_mode = 0, dn_wait = 0, dn_cnt = 0;
  logic [7:0] dn_id, dn_len;
  logic [DW-1:0] dn_rdata;
  logic [1:0] dn_rresp;

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic txn_t mk_txn(logic wr, logic [7:0] id, logic [31:0] addr, logic [7:0] len);
    txn_t t;
    t.wr = wr; t.id = id; t.addr = addr; t.len = len;
    t.size = 3'($urandom); t.burst = 2'($urandom); t.lock = 1'($urandom);
    return t;
  endfunction

  task automatic push_write(txn_t t, int bad_last_beat);
    wbeat_t b;
    aw_q.push_back(t);
    for (int i = 0; i <= int'(t.len); i++) begin
      b.data = rand_data();
      b.strb = 16'($urandom);
      b.last = (i == int'(t.len));
      if (i == bad_last_beat) b.last = ~b.last;
      w_q.push_back(b);
    end
  endtask

  task automatic clear_logs();
    a_log.delete(); mw_log.delete(); r_log.delete(); r_sent.delete();
    b_log.delete(); bresp_log.delete(); grant_type.delete(); grant_cyc.delete();
    rise_cyc.delete(); rdone_cyc.delete();
  endtask

  // One clock: drive both sides on the falling edge, then record handshakes
  task automatic cycle();
    wbeat_t wb;
    rbeat_t rb;
    txn_t   t;
    @(negedge io_memoryClk);
    cyc++;
    s_awvalid = (aw_q.size() > 0);
    if (s_awvalid) begin
      s_awid = aw_q[0].id; s_awaddr = aw_q[0].addr; s_awlen = aw_q[0].len;
      s_awsize = aw_q[0].size; s_awburst = aw_q[0].burst; s_awlock = aw_q[0].lock;
    end
    s_arvalid = (ar_q.size() > 0);
    if (s_arvalid) begin
      s_arid = ar_q[0].id; s_araddr = ar_q[0].addr; s_arlen = ar_q[0].len;
      s_arsize = ar_q[0].size; s_arburst = ar_q[0].burst; s_arlock = ar_q[0].lock;
    end
    s_wvalid = (w_q.size() > 0) && ($urandom_range(99) < wvalid_pct);
    if (w_q.size() > 0) begin
      s_wdata = w_q[0].data; s_wstrb = w_q[0].strb; s_wlast = w_q[0].last;
    end
    s_bready = ($urandom_range(99) < bready_pct);
    s_rready = ($urandom_range(99) < rready_pct);
    if (dn_mode == 0 && m_avalid === 1'b1) begin
      dn_mode = 1; dn_wait = aready_delay;
    end
    m_aready = (dn_mode == 1) && (dn_wait == 0);
    m_wready = (dn_mode == 2) && ($urandom_range(99) < wready_pct);
    m_bvalid = (dn_mode == 3);
    m_bid    = dn_id;
    m_rvalid = (dn_mode == 4) && ($urandom_range(99) < rvalid_pct);
    m_rid    = dn_id;
    m_rdata  = dn_rdata;
    m_rresp  = dn_rresp;
    m_rlast  = (dn_mode == 4) && (dn_cnt == int'(dn_len));
    #1;
    if (s_awvalid && s_awready === 1'b1) begin
      void'(aw_q.pop_front()); grant_type.push_back(1'b1); grant_cyc.push_back(cyc);
    end
    if (s_arvalid && s_arready === 1'b1) begin
      void'(ar_q.pop_front()); grant_type.push_back(1'b0); grant_cyc.push_back(cyc);
    end
    if (m_avalid === 1'b1 && !prev_avalid) rise_cyc.push_back(cyc);
    prev_avalid = (m_avalid === 1'b1);
    if (m_avalid === 1'b1 && m_aready) begin
      t.id = m_aid; t.addr = m_aaddr; t.len = m_alen; t.size = m_asize;
      t.burst = m_aburst; t.lock = m_alock[0]; t.wr = m_atype;
      if (m_alock[1] !== 1'b0) t.lock = 1'bx;
      a_log.push_back(t);
      dn_mode = m_atype ? 2 : 4; dn_id = m_aid; dn_len = m_alen; dn_cnt = 0;
      dn_rdata = rand_data(); dn_rresp = 2'($urandom);
    end else if (dn_mode == 1 && dn_wait > 0) begin
      dn_wait--;
    end
    if (s_wvalid && s_wready === 1'b1) void'(w_q.pop_front());
    if (m_wvalid === 1'b1 && m_wready) begin
      wb.data = m_wdata; wb.strb = m_wstrb; wb.last = m_wlast;
      mw_log.push_back(wb);
      if (dn_mode == 2) begin
        if (dn_cnt == int'(dn_len)) dn_mode = 3; else dn_cnt++;
      end
    end
    if (s_bvalid === 1'b1 && s_bready) begin
      b_log.push_back(s_bid); bresp_log.push_back(s_bresp);
    end
    if (m_bvalid && m_bready === 1'b1) dn_mode = 0;
    if (s_rvalid === 1'b1 && s_rready) begin
      rb.data = s_rdata; rb.id = s_rid; rb.resp = s_rresp; rb.last = s_rlast;
      r_log.push_back(rb);
      if (s_rlast) rdone_cyc.push_back(cyc);
    end
    if (m_rvalid && m_rready === 1'b1) begin
      rb.data = dn_rdata; rb.id = dn_id; rb.resp = dn_rresp; rb.last = m_rlast;
      r_sent.push_back(rb);
      if (m_rlast) dn_mode = 0;
      else begin dn_cnt++; dn_rdata = rand_data(); dn_rresp = 2'($urandom); end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycle(); cycle();
    aw_q.delete(); ar_q.delete(); w_q.delete();
    dn_mode = 0; prev_avalid = 1'b0;
    clear_logs();
    resetn = 1'b1;
    cycle();
  endtask

  // Run until n address transactions have been issued and everything drained
  task automatic wait_done(int n, string name);
    int k = 0;
    while (!(a_log.size() >= n && aw_q.size() == 0 && ar_q.size() == 0 &&
             w_q.size() == 0 && dn_mode == 0) && k < 3000) begin
      cycle(); k++;
    end
    cycle();
    total++;
    if (k >= 3000) begin
      bad++;
      $display("FAIL %s timeout: issued=%0d required=%0d", name, a_log.size(), n);
    end
  endtask

  task automatic chk_txn(string name, int idx, txn_t exp);
    total++;
    if (idx >= a_log.size()) begin
      bad++; $display("FAIL %s: address txn %0d missing", name, idx);
    end else if (a_log[idx] !== exp) begin
      bad++;
      $display("FAIL %s: got wr=%0d id=%h addr=%h len=%0d sz=%0d bu=%0d lk=%b required wr=%0d id=%h addr=%h len=%0d sz=%0d bu=%0d lk=%b",
               name, a_log[idx].wr, a_log[idx].id, a_log[idx].addr, a_log[idx].len, a_log[idx].size,
               a_log[idx].burst, a_log[idx].lock, exp.wr, exp.id, exp.addr, exp.len, exp.size, exp.burst, exp.lock);
    end
  endtask

  task automatic test_reset();
    txn_t t;
    resetn = 1'b0;
    t = mk_txn(1'b1, 8'h11, 32'h40, 8'd0);
    aw_q.push_back(t);
    t.wr = 1'b0;
    ar_q.push_back(t);
    cycle(); cycle(); cycle();
    total++;
    if ({s_awready, s_arready, m_avalid, m_wvalid, s_wready, s_bvalid, m_bready, s_rvalid, m_rready} !== 9'b0) begin
      bad++; $display("FAIL reset_valids: got %b required 000000000",
        {s_awready, s_arready, m_avalid, m_wvalid, s_wready, s_bvalid, m_bready, s_rvalid, m_rready});
    end
    total++;
    if ({m_aid, m_aaddr, m_alen, m_atype, err_wlast} !== 50'b0) begin
      bad++; $display("FAIL reset_regs: got aid=%h aaddr=%h alen=%h atype=%b err=%b required zeros",
                      m_aid, m_aaddr, m_alen, m_atype, err_wlast);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    txn_t t;
    clear_logs();
    t = mk_txn(1'b1, 8'h5A, 32'h100, 8'd3);
    push_write(t, -1);
    for (int i = 0; i < 4; i++) mw_log.push_back(w_q[i]);
    for (int i = 0; i < 4; i++) r_sent.push_back('{data: w_q[i].data, id: 8'h0, resp: 2'b0, last: w_q[i].last});
    mw_log.delete();
    wait_done(1, "single_write");
    chk_txn("single_write_addr", 0, t);
    total++;
    if (mw_log.size() != 4) begin
      bad++; $display("FAIL single_write_beats: got %0d required 4", mw_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (mw_log[i].data !== r_sent[i].data || mw_log[i].last !== (i == 3)) begin
          bad++; $display("FAIL single_write_beat%0d: got data=%h last=%b required data=%h last=%b",
                          i, mw_log[i].data, mw_log[i].last, r_sent[i].data, (i == 3));
        end
      end
    end
    total++;
    if (b_log.size() != 1 || b_log[0] !== 8'h5A || bresp_log[0] !== 2'b00) begin
      bad++; $display("FAIL single_write_b: got count=%0d bid=%h required count=1 bid=5a", b_log.size(),
                      (b_log.size() > 0) ? b_log[0] : 8'hxx);
    end
    total++;
    if (err_wlast !== 1'b0) begin
      bad++; $display("FAIL single_write_err: got %b required 0", err_wlast);
    end
  endtask

  task automatic test_single_read();
    txn_t t;
    clear_logs();
    t = mk_txn(1'b0, 8'hC3, 32'h200, 8'd0);
    ar_q.push_back(t);
    wait_done(1, "single_read");
    chk_txn("single_read_addr", 0, t);
    total++;
    if (grant_cyc.size() < 1 || rise_cyc.size() < 1 || rise_cyc[0] != grant_cyc[0] + 1) begin
      bad++; $display("FAIL single_read_latency: got avalid at %0d required %0d",
                      (rise_cyc.size() > 0) ? rise_cyc[0] : -1, (grant_cyc.size() > 0) ? grant_cyc[0] + 1 : -1);
    end
    total++;
    if (r_log.size() != 1 || r_sent.size() != 1 || r_log[0] !== r_sent[0] || r_log[0].last !== 1'b1) begin
      bad++; $display("FAIL single_read_data: got %0d beats required 1 matching beat with rlast", r_log.size());
    end
  endtask

  task automatic test_arbitration();
    txn_t t;
    logic [3:0] got;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      t = mk_txn(1'b1, 8'(8'h20 + i), 32'h1000 + 32'(i * 64), 8'($urandom_range(2)));
      push_write(t, -1);
      t = mk_txn(1'b0, 8'(8'h30 + i), 32'h2000 + 32'(i * 64), 8'($urandom_range(2)));
      ar_q.push_back(t);
    end
    wait_done(4, "arbitration");
    got = 4'bxxxx;
    for (int i = 0; i < 4 && i < a_log.size(); i++) got[3-i] = a_log[i].wr;
    total++;
    if (got !== 4'b0101) begin
      bad++; $display("FAIL arb_order: got wr-sequence %b required 0101", got);
    end
    total++;
    if (grant_cyc.size() < 2 || rdone_cyc.size() < 1 || grant_cyc[1] != rdone_cyc[0] + 1) begin
      bad++; $display("FAIL arb_next_grant: got cycle %0d required %0d",
                      (grant_cyc.size() > 1) ? grant_cyc[1] : -1, (rdone_cyc.size() > 0) ? rdone_cyc[0] + 1 : -1);
    end
  endtask

  task automatic test_aready_stall();
    txn_t t, held;
    int k = 0;
    clear_logs();
    aready_delay = 10;
    t = mk_txn(1'b1, 8'h77, 32'h3300, 8'd1);
    push_write(t, -1);
    while (m_avalid !== 1'b1 && k < 50) begin cycle(); k++; end
    held.id = m_aid; held.addr = m_aaddr; held.len = m_alen; held.size = m_asize;
    held.burst = m_aburst; held.lock = m_alock[0]; held.wr = m_atype;
    for (int i = 0; i < 9; i++) begin
      cycle();
      total++;
      if (m_avalid !== 1'b1 || m_aid !== held.id || m_aaddr !== held.addr || m_alen !== held.len ||
          m_atype !== held.wr || s_wready !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d: got avalid=%b aaddr=%h wready=%b required avalid=1 aaddr=%h wready=0",
                        i, m_avalid, m_aaddr, s_wready, held.addr);
      end
    end
    aready_delay = 0;
    wait_done(1, "stall");
    chk_txn("stall_addr", 0, t);
  endtask

  task automatic test_wlast_err();
    txn_t t;
    clear_logs();
    t = mk_txn(1'b1, 8'h44, 32'h500, 8'd1);
    push_write(t, 0);
    wait_done(1, "wlast_err");
    total++;
    if (err_wlast !== 1'b1) begin
      bad++; $display("FAIL wlast_err_set: got %b required 1", err_wlast);
    end
    total++;
    if (mw_log.size() != 2 || b_log.size() != 1) begin
      bad++; $display("FAIL wlast_err_complete: got beats=%0d b=%0d required beats=2 b=1", mw_log.size(), b_log.size());
    end
    clear_logs();
    t = mk_txn(1'b1, 8'h45, 32'h600, 8'd2);
    push_write(t, -1);
    wait_done(1, "wlast_sticky");
    total++;
    if (err_wlast !== 1'b1) begin
      bad++; $display("FAIL wlast_err_sticky: got %b required 1", err_wlast);
    end
  endtask

  task automatic test_reset_mid_read();
    txn_t t;
    int k = 0;
    do_reset();
    t = mk_txn(1'b0, 8'h99, 32'h7000, 8'd7);
    ar_q.push_back(t);
    while (r_log.size() < 2 && k < 100) begin cycle(); k++; end
    resetn = 1'b0;
    cycle();
    total++;
    if ({m_avalid, m_wvalid, s_bvalid, m_bready, s_rvalid, m_rready, s_awready, s_arready} !== 8'b0) begin
      bad++; $display("FAIL reset_mid_read: got %b required 00000000",
        {m_avalid, m_wvalid, s_bvalid, m_bready, s_rvalid, m_rready, s_awready, s_arready});
    end
    total++;
    if (r_log.size() != 2) begin
      bad++; $display("FAIL reset_mid_read_beats: got %0d required 2", r_log.size());
    end
    dn_mode = 0; prev_avalid = 1'b0;
    resetn = 1'b1;
    clear_logs();
    t = mk_txn(1'b0, 8'h9A, 32'h7100, 8'd2);
    ar_q.push_back(t);
    wait_done(1, "after_reset");
    chk_txn("after_reset_addr", 0, t);
    total++;
    if (r_log.size() != 3 || r_log != r_sent) begin
      bad++; $display("FAIL after_reset_data: got %0d beats required 3 matching", r_log.size());
    end
  endtask

  task automatic test_random();
    txn_t wr_list[$], rd_list[$], exp[$], t;
    wbeat_t w_exp[$];
    int wi = 0, ri = 0;
    logic last_wr = 1'b1;
    do_reset();
    wvalid_pct = 50 + $urandom_range(50); bready_pct = 50 + $urandom_range(50);
    rready_pct = 50 + $urandom_range(50); wready_pct = 50 + $urandom_range(50);
    rvalid_pct = 50 + $urandom_range(50); aready_delay = $urandom_range(3);
    for (int i = 0; i < 12; i++) begin
      t = mk_txn(1'($urandom), 8'($urandom), $urandom, 8'($urandom_range(7)));
      if (t.wr) begin
        wr_list.push_back(t);
        push_write(t, -1);
      end else begin
        rd_list.push_back(t);
        ar_q.push_back(t);
      end
    end
    foreach (w_q[i]) w_exp.push_back(w_q[i]);
    // Reference: everything queued up front, so ties alternate, starting with read
    while (wi < wr_list.size() || ri < rd_list.size()) begin
      if (wi < wr_list.size() && (ri >= rd_list.size() || !last_wr)) begin
        exp.push_back(wr_list[wi]); wi++; last_wr = 1'b1;
      end else begin
        exp.push_back(rd_list[ri]); ri++; last_wr = 1'b0;
      end
    end
    wait_done(12, "random");
    for (int i = 0; i < 12; i++) chk_txn("random_addr", i, exp[i]);
    total++;
    if (mw_log.size() != w_exp.size()) begin
      bad++; $display("FAIL random_wbeats: got %0d required %0d", mw_log.size(), w_exp.size());
    end else begin
      foreach (w_exp[i]) begin
        total++;
        if (mw_log[i] !== w_exp[i]) begin
          bad++; $display("FAIL random_wbeat%0d: got %h required %h", i, mw_log[i].data, w_exp[i].data);
        end
      end
    end
    total++;
    if (r_log != r_sent) begin
      bad++; $display("FAIL random_rdata: got %0d beats required %0d matching", r_log.size(), r_sent.size());
    end
    total++;
    if (b_log.size() != wr_list.size()) begin
      bad++; $display("FAIL random_bcount: got %0d required %0d", b_log.size(), wr_list.size());
    end else begin
      foreach (wr_list[i]) begin
        total++;
        if (b_log[i] !== wr_list[i].id) begin
          bad++; $display("FAIL random_bid%0d: got %h required %h", i, b_log[i], wr_list[i].id);
        end
      end
    end
    total++;
    if (err_wlast !== 1'b0) begin
      bad++; $display("FAIL random_err: got %b required 0", err_wlast);
    end
    wvalid_pct = 100; bready_pct = 100; rready_pct = 100;
    wready_pct = 100; rvalid_pct = 100; aready_delay = 0;
  endtask

  initial begin
    resetn = 1'b0;
    s_awvalid = 0; s_arvalid = 0; s_wvalid = 0; s_bready = 0; s_rready = 0;
    s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0; s_awlock = 0;
    s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0; s_arlock = 0;
    s_wdata = 0; s_wstrb = 0; s_wlast = 0;
    m_aready = 0; m_wready = 0; m_bvalid = 0; m_bid = 0;
    m_rvalid = 0; m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
    test_reset();
    test_single_write();
    test_single_read();
    test_arbitration();
    test_aready_stall();
    test_wlast_err();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/axi_ddr_port_merger.md
Name: axi_ddr_port_merger

Overview:
- Upstream neighbour of the simulation external-memory controller.
- Converts a standard AXI4 slave interface (separate AW/W/B/AR/R) from the SoC into the DDR-port style master interface with a single shared address channel selected by atype (1 = write, 0 = read).
- Serialises traffic to one outstanding transaction, because the downstream port accepts a new address only after the previous burst completes.
- Round-robin arbitration between AW and AR; flags write bursts whose wlast disagrees with awlen.

Parameters:
- DATA_WIDTH, 128, data bus width for W and R; must be 32/64/128/256/512/1024.
- ID_WIDTH, 8, AXI ID width; zero-extended or truncated to the 8-bit downstream ID.
- ADDR_WIDTH, 32, address width.

Ports:
- io_memoryClk  in  1  sole clock.
- resetn  in  1  synchronous, active-low reset.
- s_aw{id,addr,len,size,burst,lock}  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  AXI write address fields.
- s_awvalid  in  1 / s_awready  out  1  write address handshake.
- s_wdata  in  DATA_WIDTH / s_wstrb  in  DATA_WIDTH/8 / s_wlast  in  1 / s_wvalid  in  1 / s_wready  out  1  write data channel.
- s_bid  out  ID_WIDTH / s_bresp  out  2 / s_bvalid  out  1 / s_bready  in  1  write response channel.
- s_ar{id,addr,len,size,burst,lock}, s_arvalid  in / s_arready  out  read address channel; widths as AW.
- s_rid  out  ID_WIDTH / s_rdata  out  DATA_WIDTH / s_rresp  out  2 / s_rlast  out  1 / s_rvalid  out  1 / s_rready  in  1  read data channel.
- m_aid  out  8 / m_aaddr  out  32 / m_alen  out  8 / m_asize  out  3 / m_aburst  out  2 / m_alock  out  2 / m_atype  out  1 / m_avalid  out  1 / m_aready  in  1  shared address channel.
- m_wdata  out  DATA_WIDTH / m_wstrb  out  DATA_WIDTH/8 / m_wlast  out  1 / m_wvalid  out  1 / m_wready  in  1  downstream write data.
- m_bid  in  8 / m_bvalid  in  1 / m_bready  out  1  downstream write response.
- m_rid  in  8 / m_rdata  in  DATA_WIDTH / m_rresp  in  2 / m_rlast  in  1 / m_rvalid  in  1 / m_rready  out  1  downstream read data.
- err_wlast  out  1  sticky flag: write burst beat count disagreed with s_wlast.

Behaviour:
- Reset (resetn=0 at a clock edge): state IDLE; all valid/ready outputs 0; m_a* registers 0; beat counter 0; err_wlast 0; last_grant = write, so read wins the first tie.
- Reset mid-burst: aborts the transaction immediately; no further handshakes are issued.
- IDLE:
  - Grant write if s_awvalid and (!s_arvalid or last_grant == read); otherwise grant read if s_arvalid.
  - s_awready/s_arready are combinational: high only in IDLE for the granted channel.
  - On grant: latch ID, addr, len, size, burst and lock into the m_a* registers; m_alock = {1'b0, lock}; m_atype = 1 for write, 0 for read; update last_grant; go to A_REQ.
- A_REQ:
  - m_avalid = 1, held until m_aready.
  - Minimum latency: grant at cycle N, m_avalid high at N+1.
  - On m_aready: W_DATA if write, R_DATA if read; m_avalid drops in the same cycle.
- W_DATA:
  - Pass-through: m_wvalid = s_wvalid, s_wready = m_wready; data, strb and last forwarded unchanged.
  - Beat counter increments on each s_wvalid & m_wready.
  - On the handshake where counter == m_alen: go to B_RESP and clear the counter.
  - err_wlast sets if s_wlast is high on any earlier beat, or low on that final beat.
- B_RESP:
  - Pass-through: s_bvalid = m_bvalid, m_bready = s_bready, s_bid = m_bid, s_bresp = 2'b00.
  - Go to IDLE on handshake.
- R_DATA:
  - Pass-through of R; s_rid = m_rid.
  - Go to IDLE on s_rvalid & s_rready & s_rlast.
- Outside their own states, s_wready, m_wvalid, s_bvalid, m_bready, s_rvalid and m_rready are forced to 0.
- A single transaction is in flight at any time; the next grant is evaluated in IDLE the cycle after completion.
- Lengths are passed through unchanged (alen = beats − 1, 0..255); the beat counter is 8 bits and never wraps within a legal burst.

Decomposition:
- Shared package holds: state encoding (IDLE, A_REQ, W_DATA, B_RESP, R_DATA), DDR_ID_WIDTH = 8, and the ATYPE_WRITE/ATYPE_READ constants.
- One natural sub-module, axi_rr_arbiter2: two-request round-robin arbiter with a last-grant register and enable.
- FSM, latches and pass-through muxing stay at top level.

Test Plan:
- Single write: awaddr=0x100, awlen=3, 4 W beats with wlast on beat 3 → m_atype=1, m_aaddr=0x100, m_alen=3; 4 beats forwarded; one B with bid = awid; err_wlast=0.
- Single read: araddr=0x200, arlen=0 → m_avalid at grant+1, m_atype=0; one R beat with rlast=1; FSM returns to IDLE.
- AW and AR valid on the same cycle straight after reset → read granted first, write granted the cycle after the read completes; two alternating simultaneous pairs → grant order R, W, R, W.
- Downstream m_aready held low for 10 cycles → m_avalid and the m_a* fields stay stable; no s_wready during A_REQ.
- Write with awlen=1 but wlast on beat 0 → err_wlast=1 and stays set; burst still completes after 2 beats.
- resetn deasserted during beat 2 of an 8-beat read → all valids 0 on the next edge; a new AR afterwards completes normally.
